// File: rtl/config_loader_pkg.sv
// Shared constants for the configuration loader: memory word widths,
// words-per-entry, header layout, opcode/mem_sel encodings and FSM states.
package config_loader_pkg;

   localparam int DSIZE_DEF              = 16;
   localparam int STDP_WIN_BIT_WIDTH_DEF = 8;
   localparam int AER_BIT_WIDTH_DEF      = 32;

   // Memory A entry: {LTP_Win, LTD_Win, LTP_LrnRt, LTD_LrnRt, biasLrnMode}
   function automatic int calc_mem_width_a(input int stdp_w, input int dsize);
      return 2*stdp_w + 2*dsize + 1;
   endfunction

   // Memory B entry: {NurnType, RandTh, Th_Mask, RstPot, SpikeAER}
   function automatic int calc_mem_width_b(input int dsize, input int aer_w);
      return 2 + 2*dsize + aer_w;
   endfunction

   // Number of stream words needed to carry one memory entry
   function automatic int calc_wpe(input int mem_w, input int word_w);
      return (mem_w + word_w - 1) / word_w;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   localparam int MEM_WIDTH_A = calc_mem_width_a(STDP_WIN_BIT_WIDTH_DEF, DSIZE_DEF);
   localparam int MEM_WIDTH_B = calc_mem_width_b(DSIZE_DEF, AER_BIT_WIDTH_DEF);
   localparam int MEM_WIDTH_C = 1;

   localparam int WPE_A = calc_wpe(MEM_WIDTH_A, AER_BIT_WIDTH_DEF);
   localparam int WPE_B = calc_wpe(MEM_WIDTH_B, AER_BIT_WIDTH_DEF);
   localparam int WPE_C = calc_wpe(MEM_WIDTH_C, AER_BIT_WIDTH_DEF);

   localparam logic [3:0] OPC_WRITE   = 4'h1;
   localparam logic [1:0] MEM_SEL_A   = 2'd0;
   localparam logic [1:0] MEM_SEL_B   = 2'd1;
   localparam logic [1:0] MEM_SEL_C   = 2'd2;
   localparam logic [1:0] MEM_SEL_BAD = 2'd3;

   localparam int HDR_OPC_LSB  = 28;
   localparam int HDR_OPC_W    = 4;
   localparam int HDR_SEL_LSB  = 26;
   localparam int HDR_SEL_W    = 2;
   localparam int HDR_CNT_LSB  = 16;
   localparam int HDR_CNT_W    = 10;
   localparam int HDR_ADDR_LSB = 0;
   localparam int HDR_ADDR_W   = 16;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_COLLECT = 3'd1;
   localparam logic [2:0] ST_WRITE   = 3'd2;
   localparam logic [2:0] ST_DRAIN   = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/config_loader_if.sv
// Configuration word stream: valid/ready handshake carrying header and payload words.
interface config_loader_if
   import config_loader_pkg::*;
#(
   parameter int AER_BIT_WIDTH = AER_BIT_WIDTH_DEF
);
   logic [AER_BIT_WIDTH-1:0] cfgWord_i;
   logic                     cfgValid_i;
   logic                     cfgReady_o;

   modport master (output cfgWord_i, output cfgValid_i, input  cfgReady_o);
   modport slave  (input  cfgWord_i, input  cfgValid_i, output cfgReady_o);
endinterface

// File: rtl/config_loader_packer.sv
// Word packer: shifts stream words in from the top and presents the last
// wpe_i words right-aligned, first word in the least significant slot.
module config_word_packer
   import config_loader_pkg::*;
#(
   parameter int WORD_W    = AER_BIT_WIDTH_DEF,
   parameter int MAX_WORDS = 3,
   parameter int CNT_W     = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic                        clr_i,
   input  logic                        shift_i,
   input  logic [WORD_W-1:0]           word_i,
   input  logic [CNT_W-1:0]            wpe_i,
   output logic [MAX_WORDS*WORD_W-1:0] data_o,
   output logic                        last_o,
   output logic                        full_o
);
   localparam int TOT_W = MAX_WORDS * WORD_W;

   logic [TOT_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state: clear restarts the word count; a shift pushes the new word in at the top
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (shift_i) begin
         shreg_d = (shreg_q >> WORD_W) | (TOT_W'(word_i) << (TOT_W - WORD_W));
         cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   // Packer state registers; a reset drops any partially collected entry
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Align so that word 0 of the entry lands at bit 0 regardless of entry length
   always_comb begin
      data_o = shreg_q >> ((MAX_WORDS - int'(wpe_i)) * WORD_W);
      last_o = (cnt_q == wpe_i - CNT_W'(1));
      full_o = (cnt_q == wpe_i);
   end

endmodule

// File: rtl/config_loader.sv
// Configuration loader: parses header + payload words from the config stream
// and issues one write per assembled entry into memory A, B or C.
module config_loader
   import config_loader_pkg::*;
#(
   parameter int NUM_NURNS          = 256,
   parameter int NUM_AXONS          = 256,
   parameter int DSIZE              = 16,
   parameter int STDP_WIN_BIT_WIDTH = 8,
   parameter int NURN_CNT_BIT_WIDTH = 8,
   parameter int AXON_CNT_BIT_WIDTH = 8,
   parameter int AER_BIT_WIDTH      = 32,
   localparam int MW_A   = calc_mem_width_a(STDP_WIN_BIT_WIDTH, DSIZE),
   localparam int MW_B   = calc_mem_width_b(DSIZE, AER_BIT_WIDTH),
   localparam int ADDR_W = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   config_loader_if.slave                cfg_if,
   output logic                          wrEn_A_o,
   output logic [NURN_CNT_BIT_WIDTH-1:0] wrAddr_A_o,
   output logic [MW_A-1:0]               wrData_A_o,
   output logic                          wrEn_B_o,
   output logic [NURN_CNT_BIT_WIDTH-1:0] wrAddr_B_o,
   output logic [MW_B-1:0]               wrData_B_o,
   output logic                          wrEn_C_o,
   output logic [ADDR_W-1:0]             wrAddr_C_o,
   output logic [MEM_WIDTH_C-1:0]        wrData_C_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o
);
   localparam int WPE_A_L = calc_wpe(MW_A, AER_BIT_WIDTH);
   localparam int WPE_B_L = calc_wpe(MW_B, AER_BIT_WIDTH);
   localparam int WPE_C_L = calc_wpe(MEM_WIDTH_C, AER_BIT_WIDTH);
   localparam int WPE_MAX = max3(WPE_A_L, WPE_B_L, WPE_C_L);
   localparam int CNT_W   = $clog2(WPE_MAX + 1);
   localparam int DRN_W   = HDR_CNT_W + CNT_W;

   logic [2:0]                     state_q, state_d;
   logic [1:0]                     sel_q, sel_d;
   logic [ADDR_W-1:0]              addr_q, addr_d;
   logic [HDR_CNT_W-1:0]           ent_q, ent_d;
   logic [CNT_W-1:0]               wpe_q, wpe_d;
   logic [DRN_W-1:0]               drain_q, drain_d;

   logic [HDR_OPC_W-1:0]           hdr_opc;
   logic [HDR_SEL_W-1:0]           hdr_sel;
   logic [HDR_CNT_W-1:0]           hdr_cnt;
   logic [HDR_ADDR_W-1:0]          hdr_addr;
   logic [31:0]                    hdr_end, hdr_depth;
   logic                           hdr_fmt_ok, hdr_ok;
   logic [CNT_W-1:0]               hdr_wpe;

   logic                           ready_w, xfer;
   logic                           pk_clr, pk_shift, pk_last, pk_full;
   logic [WPE_MAX*AER_BIT_WIDTH-1:0] pk_data;
   logic                           wr_act;

   config_word_packer #(
      .WORD_W    (AER_BIT_WIDTH),
      .MAX_WORDS (WPE_MAX),
      .CNT_W     (CNT_W)
   ) u_packer (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (pk_clr),
      .shift_i (pk_shift),
      .word_i  (cfg_if.cfgWord_i),
      .wpe_i   (wpe_q),
      .data_o  (pk_data),
      .last_o  (pk_last),
      .full_o  (pk_full)
   );

   // Header decode and range check; the 32-bit sum cannot wrap, so overflow is rejected
   always_comb begin
      hdr_opc    = cfg_if.cfgWord_i[HDR_OPC_LSB  +: HDR_OPC_W];
      hdr_sel    = cfg_if.cfgWord_i[HDR_SEL_LSB  +: HDR_SEL_W];
      hdr_cnt    = cfg_if.cfgWord_i[HDR_CNT_LSB  +: HDR_CNT_W];
      hdr_addr   = cfg_if.cfgWord_i[HDR_ADDR_LSB +: HDR_ADDR_W];
      hdr_end    = 32'(hdr_addr) + 32'(hdr_cnt);
      hdr_depth  = (hdr_sel == MEM_SEL_C) ? 32'(NUM_NURNS * NUM_AXONS) : 32'(NUM_NURNS);
      hdr_fmt_ok = (hdr_opc == OPC_WRITE) && (hdr_sel != MEM_SEL_BAD);
      hdr_ok     = hdr_fmt_ok && (hdr_cnt != '0) && (hdr_end <= hdr_depth);
      hdr_wpe    = CNT_W'(1);
      if (hdr_fmt_ok) begin
         case (hdr_sel)
            MEM_SEL_A: hdr_wpe = CNT_W'(WPE_A_L);
            MEM_SEL_B: hdr_wpe = CNT_W'(WPE_B_L);
            default:   hdr_wpe = CNT_W'(WPE_C_L);
         endcase
      end
   end

   // Stream acceptance: never during WRITE/DONE, nor once a drain has run out, nor in reset
   always_comb begin
      ready_w = rst_n_i && ((state_q == ST_IDLE) || (state_q == ST_COLLECT) ||
                            ((state_q == ST_DRAIN) && (drain_q != '0)));
      xfer    = cfg_if.cfgValid_i && ready_w;
   end

   assign cfg_if.cfgReady_o = ready_w;

   // FSM next-state and datapath control
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      addr_d   = addr_q;
      ent_d    = ent_q;
      wpe_d    = wpe_q;
      drain_d  = drain_q;
      pk_clr   = 1'b0;
      pk_shift = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               pk_clr = 1'b1;
               wpe_d  = hdr_wpe;
               if (hdr_ok) begin
                  state_d = ST_COLLECT;
                  sel_d   = hdr_sel;
                  addr_d  = ADDR_W'(hdr_addr);
                  ent_d   = hdr_cnt;
               end else begin
                  state_d = ST_DRAIN;
                  drain_d = DRN_W'(hdr_cnt) * DRN_W'(hdr_wpe);
               end
            end
         end
         ST_COLLECT: begin
            if (xfer) begin
               pk_shift = 1'b1;
               if (pk_last) state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            pk_clr  = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
            ent_d   = ent_q - HDR_CNT_W'(1);
            state_d = (ent_q == HDR_CNT_W'(1)) ? ST_DONE : ST_COLLECT;
         end
         ST_DRAIN: begin
            if (drain_q == '0) begin
               state_d = ST_IDLE;
            end else if (xfer) begin
               drain_d = drain_q - DRN_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and address registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         sel_q   <= MEM_SEL_A;
         addr_q  <= '0;
         ent_q   <= '0;
         wpe_q   <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         ent_q   <= ent_d;
         wpe_q   <= wpe_d;
         drain_q <= drain_d;
      end
   end

   // Write ports and status, all decoded from registered state
   always_comb begin
      wr_act     = (state_q == ST_WRITE) && pk_full;
      wrEn_A_o   = wr_act && (sel_q == MEM_SEL_A);
      wrEn_B_o   = wr_act && (sel_q == MEM_SEL_B);
      wrEn_C_o   = wr_act && (sel_q == MEM_SEL_C);
      wrAddr_A_o = addr_q[NURN_CNT_BIT_WIDTH-1:0];
      wrAddr_B_o = addr_q[NURN_CNT_BIT_WIDTH-1:0];
      wrAddr_C_o = addr_q;
      wrData_A_o = pk_data[MW_A-1:0];
      wrData_B_o = pk_data[MW_B-1:0];
      wrData_C_o = pk_data[MEM_WIDTH_C-1:0];
      busy_o     = (state_q != ST_IDLE);
      done_o     = (state_q == ST_DONE);
      err_o      = (state_q == ST_DRAIN) && (drain_q == '0);
   end

endmodule
